pipe_sequencer: RTL and testbench
=================================

// Module: pipe_sequencer
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. It merges the forwarding unit's
//  load-use stall, EX-stage taken branch/jump, instruction/data memory wait and debug halt.
//  It drives per-stage register enables and flushes. It also owns the registered
//  bubble-after-load flag (bubble_ma) consumed by forwarding logic.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive DMEM_WAIT cycles before entering ERR (1..255)
// PORTS
//  clk          in   1  clock
//  rst          in   1  reset, synchronous, active-high
//  ldu_stall_i  in   1  load-use hazard detected (EX load dst == ID src)
//  br_taken_i   in   1  branch/jump resolved taken in EX this cycle
//  imem_ready_i in   1  instruction fetch data valid this cycle
//  dmem_req_i   in   1  MEM stage holds an active load/store
//  dmem_ready_i in   1  data memory completes access this cycle
//  halt_i       in   1  debug halt request (level)
//  resume_i     in   1  debug resume pulse
//  pc_en        out  1  PC update enable
//  ifid_en      out  1  IF/ID load enable;  ifid_flush out 1 IF/ID -> NOP
//  idex_en      out  1  ID/EX load enable;  idex_flush out 1 ID/EX -> NOP
//  exmem_en     out  1  EX/MEM load enable; memwb_en   out 1 MEM/WB load enable
//  bubble_ma    out  1  registered: previous cycle inserted a load-use bubble
//  mem_err      out  1  sticky data-memory timeout flag
//  state_o      out  2  current FSM state (debug)
// BEHAVIOUR
//  States: RUN=0, DMEM_WAIT=1, HALT=2, ERR=3. Reset -> RUN, cnt=0, bubble_ma=0, mem_err=0,
//   halt_pend=0. While rst=1: all *_en=0, ifid_flush=idex_flush=1.
//  RUN priority, highest first. Outputs are combinational from state + inputs:
//   1 dmem_req_i & !dmem_ready_i: all en=0, no flush; next DMEM_WAIT, cnt=1.
//   2 halt_i | halt_pend: all en=0; next HALT; clear halt_pend.
//   3 br_taken_i: all en=1, ifid_flush=idex_flush=1. Branch beats a simultaneous
//     ldu_stall_i, because the ID instruction is wrong-path.
//   4 ldu_stall_i: pc_en=ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
//   5 !imem_ready_i: pc_en=0, ifid_flush=1, all other en=1 (bubble into ID).
//   6 else: all en=1, no flush.
//  bubble_ma <= (state==RUN && case 4 taken). Updated every cycle; 0 in any other case.
//  DMEM_WAIT: freeze (all en=0, no flush). dmem_ready_i=1 -> RUN the next cycle. The
//   release cycle itself still freezes. Otherwise cnt++. cnt==MEM_TIMEOUT with no ready
//   -> ERR. halt_i seen here sets halt_pend; the halt is taken on the first RUN cycle.
//  HALT: freeze. resume_i=1 -> RUN. resume_i=0 -> stay, even if halt_i has dropped.
//   halt_pend is cleared while in HALT.
//  ERR: freeze, mem_err=1, sticky. Only rst exits.
//  A simultaneous dmem_ready_i and timeout count resolves to ready (RUN).
//  rst asserted mid-wait/halt discards cnt and halt_pend on that edge.
//  cnt is 8 bits and saturates. It never wraps in DMEM_WAIT because ERR is taken first.
//  Register-to-output latency: the bubble_ma, mem_err and state_o flops, 1 cycle.
//   Enables and flushes: 0 cycles.
// STRUCTURE
//  pipe_pkg:
//   - state localparams RUN/DMEM_WAIT/HALT/ERR (2-bit)
//   - MEM_TIMEOUT default
//  Sub-module wait_timer (clear, inc, limit -> expired) holds the DMEM_WAIT counter.
//  FSM, priority decode and flag flops live in pipe_sequencer.
// TESTING
//  T1 ldu_stall_i=1 for 1 cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1;
//     next cycle bubble_ma=1, then 0.
//  T2 br_taken_i=1 with ldu_stall_i=1 in the same cycle -> ifid_flush=idex_flush=1,
//     pc_en=1, next-cycle bubble_ma=0.
//  T3 dmem_req_i=1, dmem_ready_i=0 for 4 cycles, then 1 -> state_o=1 for 5 cycles with
//     all en=0, then RUN with en=1.
//  T4 MEM_TIMEOUT=3, dmem_ready_i held 0 -> ERR after the 3rd wait cycle. mem_err=1 holds
//     until rst. Then rst 1 cycle -> mem_err=0, state_o=0.
//  T5 halt_i pulsed during DMEM_WAIT -> after dmem_ready_i: RUN one cycle (frozen),
//     then HALT. resume_i pulse -> RUN with all en=1.
//  T6 imem_ready_i=0 for 2 cycles -> pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1
//     for both cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared state encoding and sizing for the pipeline stall/flush sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    HALT      = 2'd2,
    ERR       = 2'd3
  } state_t;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/wait_timer.sv
// Saturating wait-cycle counter; expired is combinational from the count (0-cycle latency).
// clear wins over inc; the count never wraps.
module wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign expired = (cnt == limit);

endmodule

// File: rtl/pipe_sequencer.sv
// Merges load-use, branch, memory-wait and debug-halt into per-stage enables/flushes (0-cycle).
// bubble_ma, mem_err and state_o are registered (1-cycle); memory waits freeze the whole pipe.
module pipe_sequencer
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ldu_stall_i,
  input  logic       br_taken_i,
  input  logic       imem_ready_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ready_i,
  input  logic       halt_i,
  input  logic       resume_i,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       bubble_ma,
  output logic       mem_err,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  state_t state;
  state_t state_nx;
  logic   halt_pend;
  logic   halt_pend_nx;
  logic   ldu_bubble;
  logic   cnt_inc;
  logic   cnt_expired;

  wait_timer #(.W(CNT_W)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!cnt_inc),
    .inc     (cnt_inc),
    .limit   (LIMIT),
    .expired (cnt_expired)
  );

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    state_nx     = state;
    halt_pend_nx = halt_pend;
    ldu_bubble   = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          state_nx = DMEM_WAIT;
          cnt_inc  = 1'b1;
        end else if (halt_i || halt_pend) begin
          state_nx     = HALT;
          halt_pend_nx = 1'b0;
        end else if (br_taken_i) begin
          // Branch outranks load-use: the stalled ID instruction is wrong-path anyway.
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (ldu_stall_i) begin
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ldu_bubble = 1'b1;
        end else if (!imem_ready_i) begin
          {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
          ifid_flush = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
      DMEM_WAIT: begin
        if (halt_i) halt_pend_nx = 1'b1;
        // Ready wins over a coincident timeout.
        if (dmem_ready_i)     state_nx = RUN;
        else if (cnt_expired) state_nx = ERR;
        else                  cnt_inc  = 1'b1;
      end
      HALT: begin
        halt_pend_nx = 1'b0;
        if (resume_i) state_nx = RUN;
      end
      default: state_nx = ERR;
    endcase
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      halt_pend <= 1'b0;
      bubble_ma <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      halt_pend <= halt_pend_nx;
      bubble_ma <= ldu_bubble;
      if (state_nx == ERR) mem_err <= 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench: dut_a uses the default timeout, dut_b a timeout of 3; both share inputs.
module tb_pipe_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic ldu_stall_i, br_taken_i, imem_ready_i, dmem_req_i, dmem_ready_i, halt_i, resume_i;

  logic pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a, exmem_en_a, memwb_en_a;
  logic bubble_ma_a, mem_err_a;
  logic [1:0] state_a;
  logic pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_flush_b, exmem_en_b, memwb_en_b;
  logic bubble_ma_b, mem_err_b;
  logic [1:0] state_b;

  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a, exmem_en_a, memwb_en_a};
  assign ctl_b = {pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_flush_b, exmem_en_b, memwb_en_b};

  always #5 clk = ~clk;

  pipe_sequencer dut_a (
    .clk(clk), .rst(rst), .ldu_stall_i(ldu_stall_i), .br_taken_i(br_taken_i),
    .imem_ready_i(imem_ready_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .halt_i(halt_i), .resume_i(resume_i), .pc_en(pc_en_a), .ifid_en(ifid_en_a),
    .ifid_flush(ifid_flush_a), .idex_en(idex_en_a), .idex_flush(idex_flush_a),
    .exmem_en(exmem_en_a), .memwb_en(memwb_en_a), .bubble_ma(bubble_ma_a),
    .mem_err(mem_err_a), .state_o(state_a)
  );

  pipe_sequencer #(.MEM_TIMEOUT(3)) dut_b (
    .clk(clk), .rst(rst), .ldu_stall_i(ldu_stall_i), .br_taken_i(br_taken_i),
    .imem_ready_i(imem_ready_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .halt_i(halt_i), .resume_i(resume_i), .pc_en(pc_en_b), .ifid_en(ifid_en_b),
    .ifid_flush(ifid_flush_b), .idex_en(idex_en_b), .idex_flush(idex_flush_b),
    .exmem_en(exmem_en_b), .memwb_en(memwb_en_b), .bubble_ma(bubble_ma_b),
    .mem_err(mem_err_b), .state_o(state_b)
  );

  // Input vector order: {ldu, br, imem_ready, dmem_req, dmem_ready, halt, resume}
  localparam logic [6:0] IDLE   = 7'b0010000;
  localparam logic [6:0] DWAIT  = 7'b0011000;
  localparam logic [6:0] DWAITH = 7'b0011010;
  localparam logic [6:0] DRDY   = 7'b0011100;
  localparam logic [6:0] RESUME = 7'b0010001;
  localparam logic [6:0] HALTBR = 7'b0110010;
  localparam logic [6:0] BR     = 7'b0110000;
  // Control order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  localparam logic [6:0] C_FRZ  = 7'b0000000;
  localparam logic [6:0] C_NRM  = 7'b1101011;
  localparam logic [6:0] C_BR   = 7'b1111111;
  localparam logic [6:0] C_LDU  = 7'b0001111;
  localparam logic [6:0] M_LDU  = 7'b1110111;
  localparam logic [6:0] C_IMEM = 7'b0111011;
  localparam logic [6:0] C_RST  = 7'b0010100;

  typedef struct {
    logic [6:0] in;
    logic [6:0] exp_ctl;
    logic [6:0] mask;
    logic       exp_bub;
    string      nm;
  } vec_t;

  vec_t vt [12];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [6:0] v);
    {ldu_stall_i, br_taken_i, imem_ready_i, dmem_req_i, dmem_ready_i, halt_i, resume_i} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle: apply inputs, check both DUTs mid-cycle, advance.
  task automatic cyc(input string nm, input logic [6:0] v,
                     input logic [6:0] ca, input logic [1:0] sa,
                     input logic [6:0] cb, input logic [1:0] sb, input logic meb);
    drv(v);
    @(negedge clk);
    chk({nm, "_ctl_a"}, {1'b0, ctl_a}, {1'b0, ca});
    chk({nm, "_st_a"}, {6'd0, state_a}, {6'd0, sa});
    chk({nm, "_ctl_b"}, {1'b0, ctl_b}, {1'b0, cb});
    chk({nm, "_st_b"}, {6'd0, state_b}, {6'd0, sb});
    chk({nm, "_err_b"}, {7'd0, mem_err_b}, {7'd0, meb});
    step();
  endtask

  task automatic rst_cyc(input string nm);
    rst = 1'b1;
    drv(IDLE);
    @(negedge clk);
    chk({nm, "_ctl_a"}, {1'b0, ctl_a}, {1'b0, C_RST});
    chk({nm, "_ctl_b"}, {1'b0, ctl_b}, {1'b0, C_RST});
    step();
    rst = 1'b0;
  endtask

  initial begin
    vt[0]  = '{IDLE,       C_NRM,  7'h7f,  1'b0, "normal"};
    vt[1]  = '{7'b1010000, C_LDU,  M_LDU,  1'b0, "ldu"};
    vt[2]  = '{IDLE,       C_NRM,  7'h7f,  1'b1, "ldu_bubble"};
    vt[3]  = '{IDLE,       C_NRM,  7'h7f,  1'b0, "bubble_clear"};
    vt[4]  = '{7'b1110000, C_BR,   7'h7f,  1'b0, "br_ldu"};
    vt[5]  = '{IDLE,       C_NRM,  7'h7f,  1'b0, "br_no_bubble"};
    vt[6]  = '{7'b0000000, C_IMEM, 7'h7f,  1'b0, "imem0_c1"};
    vt[7]  = '{7'b0000000, C_IMEM, 7'h7f,  1'b0, "imem0_c2"};
    vt[8]  = '{7'b1000000, C_LDU,  M_LDU,  1'b0, "ldu_over_imem"};
    vt[9]  = '{7'b0000000, C_IMEM, 7'h7f,  1'b1, "imem0_bubble"};
    vt[10] = '{7'b0100000, C_BR,   7'h7f,  1'b0, "br_over_imem"};
    vt[11] = '{DRDY,       C_NRM,  7'h7f,  1'b0, "dmem_hit"};

    rst = 1'b1;
    drv(IDLE);
    step();
    @(negedge clk);
    chk("rst_ctl_a", {1'b0, ctl_a}, {1'b0, C_RST});
    chk("rst_ctl_b", {1'b0, ctl_b}, {1'b0, C_RST});
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {6'd0, state_a}, 8'd0);
    chk("rst_bubble", {7'd0, bubble_ma_a}, 8'd0);
    chk("rst_mem_err", {7'd0, mem_err_a}, 8'd0);
    step();

    for (int i = 0; i < 12; i++) begin
      drv(vt[i].in);
      @(negedge clk);
      chk({vt[i].nm, "_ctl"}, {1'b0, ctl_a & vt[i].mask}, {1'b0, vt[i].exp_ctl & vt[i].mask});
      chk({vt[i].nm, "_bub"}, {7'd0, bubble_ma_a}, {7'd0, vt[i].exp_bub});
      chk({vt[i].nm, "_st"}, {6'd0, state_a}, 8'd0);
      step();
    end

    // Long wait: dut_a survives 4 idle waits; dut_b times out after its 3rd wait cycle.
    cyc("t3_enter", DWAIT, C_FRZ, 2'd0, C_FRZ, 2'd0, 1'b0);
    cyc("t3_w0",    DWAIT, C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    cyc("t3_w1",    DWAIT, C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    cyc("t3_w2",    DWAIT, C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    cyc("t3_w3",    DWAIT, C_FRZ, 2'd1, C_FRZ, 2'd3, 1'b1);
    cyc("t3_rel",   DRDY,  C_FRZ, 2'd1, C_FRZ, 2'd3, 1'b1);
    cyc("t3_run",   IDLE,  C_NRM, 2'd0, C_FRZ, 2'd3, 1'b1);
    cyc("t4_stick", BR,    C_BR,  2'd0, C_FRZ, 2'd3, 1'b1);
    rst_cyc("t4_rst");
    cyc("t4_after", IDLE,  C_NRM, 2'd0, C_NRM, 2'd0, 1'b0);

    // Ready arriving on the very cycle dut_b's count hits its limit.
    cyc("tr_enter", DWAIT, C_FRZ, 2'd0, C_FRZ, 2'd0, 1'b0);
    cyc("tr_w0",    DWAIT, C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    cyc("tr_w1",    DWAIT, C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    cyc("tr_rel",   DRDY,  C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    cyc("tr_run",   IDLE,  C_NRM, 2'd0, C_NRM, 2'd0, 1'b0);

    // Halt seen during a memory wait is deferred to the first RUN cycle.
    cyc("t5_enter", DWAIT,  C_FRZ, 2'd0, C_FRZ, 2'd0, 1'b0);
    cyc("t5_w0h",   DWAITH, C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    cyc("t5_w1",    DWAIT,  C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    cyc("t5_rel",   DRDY,   C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    cyc("t5_runfz", IDLE,   C_FRZ, 2'd0, C_FRZ, 2'd0, 1'b0);
    cyc("t5_halt",  IDLE,   C_FRZ, 2'd2, C_FRZ, 2'd2, 1'b0);
    cyc("t5_stay",  IDLE,   C_FRZ, 2'd2, C_FRZ, 2'd2, 1'b0);
    cyc("t5_resm",  RESUME, C_FRZ, 2'd2, C_FRZ, 2'd2, 1'b0);
    cyc("t5_back",  IDLE,   C_NRM, 2'd0, C_NRM, 2'd0, 1'b0);
    cyc("t5_clean", IDLE,   C_NRM, 2'd0, C_NRM, 2'd0, 1'b0);

    // Reset during a wait discards the pending halt.
    cyc("tp_enter", DWAIT,  C_FRZ, 2'd0, C_FRZ, 2'd0, 1'b0);
    cyc("tp_w0h",   DWAITH, C_FRZ, 2'd1, C_FRZ, 2'd1, 1'b0);
    rst_cyc("tp_rst");
    cyc("tp_run",   IDLE,   C_NRM, 2'd0, C_NRM, 2'd0, 1'b0);

    // Halt beats a branch in RUN; reset exits HALT.
    cyc("th_req",   HALTBR, C_FRZ, 2'd0, C_FRZ, 2'd0, 1'b0);
    cyc("th_halt",  IDLE,   C_FRZ, 2'd2, C_FRZ, 2'd2, 1'b0);
    rst_cyc("th_rst");
    cyc("th_run",   IDLE,   C_NRM, 2'd0, C_NRM, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
